// File: rtl/score_keeper.sv
// Snake-game score keeper: packed-BCD score with saturation, high score across games,
// and the display value/enable, with a blinking enable after a new high score.
module score_keeper #(
  parameter int POINTS     = 1,
  parameter int BLINK_HALF = 25000000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       eat,
  input  logic       game_over,
  output logic [7:0] num,
  output logic       enable,
  output logic [7:0] high_score,
  output logic       new_high
);

  localparam int                CNT_W    = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_HALF - 1);
  localparam logic [4:0]       PTS      = 5'(POINTS);

  typedef enum logic [1:0] {IDLE, PLAYING, OVER} state_t;

  state_t           state_q, state_d;
  logic [7:0]       score_q, score_d;
  logic [7:0]       high_q, high_d;
  logic [7:0]       num_q, num_d;
  logic             enable_q, enable_d;
  logic             new_high_q, new_high_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             start_q, eat_q, game_over_q;
  logic             start_p, eat_p, over_p;

  // BCD add of POINTS; a carry out of the tens digit pins the score at 99.
  function automatic logic [7:0] bcd_add_sat(input logic [7:0] s);
    logic [4:0] ones_sum;
    logic [4:0] tens_sum;
    logic [3:0] ones;
    ones_sum = {1'b0, s[3:0]} + PTS;
    tens_sum = {1'b0, s[7:4]};
    ones     = ones_sum[3:0];
    if (ones_sum > 5'd9) begin
      ones     = 4'(ones_sum - 5'd10);
      tens_sum = tens_sum + 5'd1;
    end
    if (tens_sum > 5'd9) return 8'h99;
    return {tens_sum[3:0], ones};
  endfunction

  always_comb begin
    start_p    = start & ~start_q;
    eat_p      = eat & ~eat_q;
    over_p     = game_over & ~game_over_q;
    state_d    = state_q;
    score_d    = score_q;
    high_d     = high_q;
    new_high_d = new_high_q;
    enable_d   = 1'b1;
    cnt_d      = '0;
    case (state_q)
      IDLE: begin
        if (start_p) begin
          state_d    = PLAYING;
          score_d    = 8'h00;
          new_high_d = 1'b0;
        end
      end
      PLAYING: begin
        // game_over wins over a same-cycle eat; the compare sees the pre-eat score.
        if (over_p) begin
          state_d = OVER;
          if (score_q > high_q) begin
            high_d     = score_q;
            new_high_d = 1'b1;
          end else begin
            new_high_d = 1'b0;
          end
        end else if (eat_p) begin
          score_d = bcd_add_sat(score_q);
        end
      end
      OVER: begin
        if (start_p) begin
          state_d    = PLAYING;
          score_d    = 8'h00;
          new_high_d = 1'b0;
        end else if (new_high_q) begin
          enable_d = enable_q;
          if (cnt_q == CNT_LAST) begin
            enable_d = ~enable_q;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
    num_d = (state_d == IDLE) ? high_d : score_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      score_q     <= 8'h00;
      high_q      <= 8'h00;
      num_q       <= 8'h00;
      enable_q    <= 1'b1;
      new_high_q  <= 1'b0;
      cnt_q       <= '0;
      start_q     <= 1'b0;
      eat_q       <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      score_q     <= score_d;
      high_q      <= high_d;
      num_q       <= num_d;
      enable_q    <= enable_d;
      new_high_q  <= new_high_d;
      cnt_q       <= cnt_d;
      start_q     <= start;
      eat_q       <= eat;
      game_over_q <= game_over;
    end
  end

  assign num        = num_q;
  assign enable     = enable_q;
  assign high_score = high_q;
  assign new_high   = new_high_q;

endmodule
